// File: rtl/serdes_frame_arbiter_pkg.sv
// Shared types and helpers for the serdes frame arbiter.
// Holds the arbiter FSM state encoding and the id-width helper used by the
// top level and the request picker.
package serdes_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serdes_frame_arbiter_picker.sv
// Request picker for the serdes frame arbiter.
// Round-robin search starting at an internal pointer that advances past the
// winner whenever a grant is accepted (en). With
// SERDES_FRAME_ARBITER_FIXED_PRIO_EN defined, the lowest-index requester
// always wins and no pointer register exists.
module serdes_rr_picker
  import serdes_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic             any,
  output logic [ID_W-1:0]  winner
);

`ifdef SERDES_FRAME_ARBITER_FIXED_PRIO_EN

  // Lowest-index valid requester wins.
  always_comb begin
    any    = |req;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{clk, reset, en};

`else

  logic [ID_W-1:0] ptr_q, ptr_d;

  // Rotate requests so bit 0 sits at the pointer, take the lowest set bit,
  // then map that offset back to an absolute index modulo N_REQ.
  always_comb begin
    logic [N_REQ-1:0] rot;
    logic [ID_W:0]    idx;
    rot    = N_REQ'({req, req} >> ptr_q);
    idx    = '0;
    any    = |req;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = {1'b0, ptr_q} + (ID_W+1)'(i);
        if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
        winner = idx[ID_W-1:0];
      end
    end
  end

  // Pointer moves just past the accepted winner; wrap is an explicit compare
  // so non-power-of-two requester counts wrap correctly.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    ptr_d = ptr_q;
    if (en) ptr_d = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/serdes_frame_arbiter.sv
// Shares one serializer among N_REQ frame producers.
// Grants whole frames, forwards the winning frame, then counts serial-side
// word handshakes to tag each word with its source id and a last-word flag.
// No new grant is issued until the current frame has fully drained.
// Optional: SERDES_FRAME_ARBITER_FIXED_PRIO_EN selects fixed priority.
module serdes_frame_arbiter
  import serdes_arb_pkg::*;
#(
  parameter  int BIT_WIDTH = 32,
  parameter  int N_SAMPLES = 8,
  parameter  int N_REQ     = 4,
  localparam int ID_W      = id_width(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] req_msg [N_REQ*N_SAMPLES],
  input  logic [N_REQ-1:0]     req_val,
  output logic [N_REQ-1:0]     req_rdy,
  output logic [BIT_WIDTH-1:0] ser_msg [N_SAMPLES],
  output logic                 ser_val,
  input  logic                 ser_rdy,
  input  logic                 mon_val,
  input  logic                 mon_rdy,
  output logic [ID_W-1:0]      send_id,
  output logic                 send_last
);

  localparam int                BEAT_W    = $clog2(N_SAMPLES + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_SAMPLES - 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ID_W-1:0]   send_id_q, send_id_d;
  logic              any_req;
  logic [ID_W-1:0]   winner;
  logic              accept;
  logic              mon_hs;
  logic              at_last;

  assign accept  = (state_q == IDLE) && any_req && ser_rdy && !reset;
  assign mon_hs  = mon_val && mon_rdy;
  assign at_last = (beat_q == LAST_BEAT);
  assign send_id = send_id_q;

  serdes_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .clk    (clk),
    .reset  (reset),
    .req    (req_val),
    .en     (accept),
    .any    (any_req),
    .winner (winner)
  );

  // Forward the winner's frame; requester 0's frame when nobody is valid.
  always_comb begin
    for (int s = 0; s < N_SAMPLES; s++) begin
      ser_msg[s] = req_msg[s];
      for (int r = 1; r < N_REQ; r++) begin
        if (winner == ID_W'(r)) ser_msg[s] = req_msg[r*N_SAMPLES + s];
      end
    end
  end

  // State, beat counter and source-id registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      send_id_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      send_id_q <= send_id_d;
    end
  end

  // Next state: grant in IDLE, count serial words in DRAIN, leave on the last.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    send_id_d = send_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = DRAIN;
          beat_d    = '0;
          send_id_d = winner;
        end
      end
      DRAIN: begin
        if (mon_hs) begin
          if (at_last) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
    endcase
  end

  // Outputs: offer a frame only in IDLE; flag the last word only in DRAIN.
  always_comb begin
    ser_val   = 1'b0;
    req_rdy   = '0;
    send_last = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          ser_val = any_req;
          for (int r = 0; r < N_REQ; r++) begin
            req_rdy[r] = ser_rdy && (winner == ID_W'(r));
          end
        end
        DRAIN: send_last = mon_val && at_last;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_frame_arbiter.sv
// Self-checking bench for serdes_frame_arbiter (default 32-bit, 8 words,
// 4 requesters). Expected values come from a transaction-level model:
// "free or busy with K words left", plus the next-priority requester index.
module tb_serdes_frame_arbiter;
  import serdes_arb_pkg::*;

  localparam int BW  = 32;
  localparam int NS  = 8;
  localparam int NR  = 4;
  localparam int IDW = id_width(NR);
`ifdef SERDES_FRAME_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [BW-1:0]   req_msg [NR*NS];
  logic [NR-1:0]   req_val;
  logic [NR-1:0]   req_rdy;
  logic [BW-1:0]   ser_msg [NS];
  logic            ser_val;
  logic            ser_rdy;
  logic            mon_val;
  logic            mon_rdy;
  logic [IDW-1:0]  send_id;
  logic            send_last;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  bit m_busy = 1'b0;
  int m_left = 0;
  int m_id   = 0;
  int m_next = 0;

  // Expected outputs for the current cycle.
  int             exp_winner;
  logic           exp_ser_val;
  logic [NR-1:0]  exp_req_rdy;
  logic           exp_send_last;
  logic [IDW-1:0] exp_send_id;

  serdes_frame_arbiter #(
    .BIT_WIDTH (BW),
    .N_SAMPLES (NS),
    .N_REQ     (NR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_msg   (req_msg),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .ser_msg   (ser_msg),
    .ser_val   (ser_val),
    .ser_rdy   (ser_rdy),
    .mon_val   (mon_val),
    .mon_rdy   (mon_rdy),
    .send_id   (send_id),
    .send_last (send_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // First valid requester at or after start, wrapping.
  function automatic int pick(input logic [NR-1:0] v, input int start);
    for (int k = 0; k < NR; k++) begin
      if (v[(start + k) % NR] === 1'b1) return (start + k) % NR;
    end
    return 0;
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int idx = -1;
    for (int i = 0; i < NR; i++) begin
      if (v[i] === 1'b1) begin
        if (idx != -1) return -2;
        idx = i;
      end
    end
    return idx;
  endfunction

  function automatic bit frame_bad(input int w);
    for (int s = 0; s < NS; s++) begin
      if (ser_msg[s] !== req_msg[w*NS + s]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic load_frames(input bit rnd);
    logic [31:0] w;
    for (int r = 0; r < NR; r++) begin
      for (int s = 0; s < NS; s++) begin
        w = $urandom();
        req_msg[r*NS + s] = rnd ? {w[31:16], 8'(r), 8'(s)} : 32'(r * 256 + s);
      end
    end
  endtask

  task automatic model_eval();
    exp_winner    = pick(req_val, FIXED ? 0 : m_next);
    exp_ser_val   = 1'b0;
    exp_req_rdy   = '0;
    exp_send_last = 1'b0;
    exp_send_id   = IDW'(m_id);
    if (!reset) begin
      if (!m_busy) begin
        exp_ser_val = |req_val;
        exp_req_rdy = NR'(ser_rdy) << exp_winner;
      end else begin
        exp_send_last = mon_val && (m_left == 1);
      end
    end
  endtask

  task automatic model_tick();
    if (reset) begin
      m_busy = 1'b0; m_left = 0; m_id = 0; m_next = 0;
    end else if (!m_busy) begin
      if ((|req_val) && ser_rdy) begin
        m_busy = 1'b1;
        m_left = NS;
        m_id   = pick(req_val, FIXED ? 0 : m_next);
        m_next = (m_id + 1) % NR;
      end
    end else if (mon_val && mon_rdy) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_val = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_val = '1; ser_rdy = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1;
    load_frames(1'b0);
    @(negedge clk);
    settle();
    n_vec++; if (ser_val !== 1'b0) begin n_bad++; $display("FAIL reset ser_val: got %b want 0", ser_val); end
    n_vec++; if (req_rdy !== 4'b0000) begin n_bad++; $display("FAIL reset req_rdy: got %b want 0000", req_rdy); end
    n_vec++; if (send_last !== 1'b0) begin n_bad++; $display("FAIL reset send_last: got %b want 0", send_last); end
    tick();
    reset = 1'b0; req_val = '0;
    settle();
    n_vec++; if (send_id !== exp_send_id) begin n_bad++; $display("FAIL reset send_id: got %0d want %0d", send_id, exp_send_id); end
    n_vec++; if (ser_val !== 1'b0) begin n_bad++; $display("FAIL idle ser_val: got %b want 0", ser_val); end
    n_vec++; if (send_last !== 1'b0) begin n_bad++; $display("FAIL idle send_last: got %b want 0", send_last); end
    tick();
    // mon handshake while idle must not disturb anything; offer a frame with ser_rdy low.
    req_val = 4'b0001; ser_rdy = 1'b0;
    settle();
    n_vec++; if (ser_val !== 1'b1) begin n_bad++; $display("FAIL idle offer ser_val: got %b want 1", ser_val); end
    n_vec++; if (req_rdy !== 4'b0000) begin n_bad++; $display("FAIL idle no-rdy req_rdy: got %b want 0000", req_rdy); end
    tick();
  endtask

  task automatic test_single_requester();
    apply_reset();
    load_frames(1'b0);
    req_val = 4'b0100; ser_rdy = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1;
    settle();
    n_vec++; if (req_rdy !== 4'b0100) begin n_bad++; $display("FAIL single grant req_rdy: got %b want 0100", req_rdy); end
    n_vec++; if (ser_msg[0] !== 32'h200 || frame_bad(2)) begin n_bad++; $display("FAIL single ser_msg: got %h.. want 00000200..", ser_msg[0]); end
    tick();
    for (int b = 0; b < NS; b++) begin
      settle();
      n_vec++; if (send_id !== 1'(2'd2) && send_id !== 2'd2) begin n_bad++; $display("FAIL single send_id beat %0d: got %0d want 2", b, send_id); end
      n_vec++; if (send_last !== (b == NS - 1)) begin n_bad++; $display("FAIL single send_last beat %0d: got %b want %b", b, send_last, (b == NS - 1)); end
      n_vec++; if (req_rdy !== 4'b0000 || ser_val !== 1'b0) begin n_bad++; $display("FAIL single drain rdy/val beat %0d: got %b/%b want 0000/0", b, req_rdy, ser_val); end
      tick();
    end
    settle();
    n_vec++; if (req_rdy !== 4'b0100) begin n_bad++; $display("FAIL single regrant req_rdy: got %b want 0100", req_rdy); end
    req_val = '0;
    settle();
    tick();
  endtask

  task automatic test_round_robin();
    int grants[$];
    int last_c = -1;
    apply_reset();
    load_frames(1'b1);
    req_val = '1; ser_rdy = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1;
    for (int c = 0; c < 100 && grants.size() < 5; c++) begin
      settle();
      n_vec++; if (ser_val !== exp_ser_val) begin n_bad++; $display("FAIL rr ser_val c%0d: got %b want %b", c, ser_val, exp_ser_val); end
      n_vec++; if (req_rdy !== exp_req_rdy) begin n_bad++; $display("FAIL rr req_rdy c%0d: got %b want %b", c, req_rdy, exp_req_rdy); end
      n_vec++; if (send_last !== exp_send_last) begin n_bad++; $display("FAIL rr send_last c%0d: got %b want %b", c, send_last, exp_send_last); end
      n_vec++; if (send_id !== exp_send_id) begin n_bad++; $display("FAIL rr send_id c%0d: got %0d want %0d", c, send_id, exp_send_id); end
      if (ser_val === 1'b1) begin
        grants.push_back(onehot_idx(req_rdy));
        if (last_c >= 0) begin
          n_vec++; if (c - last_c != NS + 1) begin n_bad++; $display("FAIL rr grant spacing: got %0d cycles want %0d", c - last_c, NS + 1); end
        end
        last_c = c;
      end
      tick();
    end
    n_vec++;
    if (grants.size() < 5) begin
      n_bad++; $display("FAIL rr timeout: got %0d grants want 5", grants.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++; if (grants[i] != (FIXED ? 0 : i % NR)) begin n_bad++; $display("FAIL rr order #%0d: got %0d want %0d", i, grants[i], FIXED ? 0 : i % NR); end
      end
    end
  endtask

  task automatic test_mon_backpressure();
    int stalls = 0;
    apply_reset();
    load_frames(1'b1);
    req_val = 4'b0010; ser_rdy = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c >= 1) mon_rdy = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      settle();
      n_vec++; if (ser_val !== exp_ser_val) begin n_bad++; $display("FAIL bp ser_val c%0d: got %b want %b", c, ser_val, exp_ser_val); end
      n_vec++; if (req_rdy !== exp_req_rdy) begin n_bad++; $display("FAIL bp req_rdy c%0d: got %b want %b", c, req_rdy, exp_req_rdy); end
      n_vec++; if (send_last !== exp_send_last) begin n_bad++; $display("FAIL bp send_last c%0d: got %b want %b", c, send_last, exp_send_last); end
      n_vec++; if (send_id !== exp_send_id) begin n_bad++; $display("FAIL bp send_id c%0d: got %0d want %0d", c, send_id, exp_send_id); end
      if (send_last === 1'b1 && mon_rdy === 1'b0) stalls++;
      tick();
      if (c == 0) req_val = '0;
    end
    n_vec++; if (stalls != 2) begin n_bad++; $display("FAIL bp last-held-while-stalled: got %0d cycles want 2", stalls); end
  endtask

  task automatic test_drop_val();
    int grants[$];
    int exp_g[3];
    exp_g = FIXED ? '{1, 1, 2} : '{1, 3, 2};
    apply_reset();
    load_frames(1'b1);
    req_val = 4'b0010; ser_rdy = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 3; c++) begin
      settle();
      n_vec++; if (req_rdy !== exp_req_rdy) begin n_bad++; $display("FAIL drop req_rdy c%0d: got %b want %b", c, req_rdy, exp_req_rdy); end
      n_vec++; if (send_id !== exp_send_id) begin n_bad++; $display("FAIL drop send_id c%0d: got %0d want %0d", c, send_id, exp_send_id); end
      if (exp_ser_val) begin
        n_vec++; if (frame_bad(exp_winner)) begin n_bad++; $display("FAIL drop ser_msg c%0d: got %h want %h", c, ser_msg[0], req_msg[exp_winner*NS]); end
      end
      if (ser_val === 1'b1) grants.push_back(onehot_idx(req_rdy));
      tick();
      if (grants.size() == 1) req_val = 4'b1010;
      else if (grants.size() >= 2) req_val = 4'b1100;
    end
    n_vec++;
    if (grants.size() < 3) begin
      n_bad++; $display("FAIL drop timeout: got %0d grants want 3", grants.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (grants[i] != exp_g[i]) begin n_bad++; $display("FAIL drop order #%0d: got %0d want %0d", i, grants[i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    load_frames(1'b0);
    req_val = 4'b0010; ser_rdy = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1;
    settle();
    tick();
    req_val = 4'b1111;
    for (int b = 0; b < 4; b++) begin
      settle();
      n_vec++; if (send_id !== 2'd1) begin n_bad++; $display("FAIL rstmid send_id beat %0d: got %0d want 1", b, send_id); end
      tick();
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_vec++; if (req_rdy !== 4'b0000) begin n_bad++; $display("FAIL rstmid req_rdy k%0d: got %b want 0000", k, req_rdy); end
      n_vec++; if (ser_val !== 1'b0 || send_last !== 1'b0) begin n_bad++; $display("FAIL rstmid val/last k%0d: got %b/%b want 0/0", k, ser_val, send_last); end
      tick();
    end
    reset = 1'b0;
    settle();
    n_vec++; if (req_rdy !== 4'b0001) begin n_bad++; $display("FAIL rstmid first grant req_rdy: got %b want 0001", req_rdy); end
    n_vec++; if (send_id !== 2'd0) begin n_bad++; $display("FAIL rstmid send_id: got %0d want 0", send_id); end
    n_vec++; if (ser_msg[0] !== 32'h0) begin n_bad++; $display("FAIL rstmid ser_msg: got %h want 00000000", ser_msg[0]); end
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 49) == 0);
      req_val = NR'($urandom());
      ser_rdy = ($urandom_range(0, 3) != 0);
      mon_val = ($urandom_range(0, 3) != 0);
      mon_rdy = ($urandom_range(0, 2) != 0);
      load_frames(1'b1);
      settle();
      n_vec++; if (ser_val !== exp_ser_val) begin n_bad++; $display("FAIL rand ser_val c%0d: got %b want %b", c, ser_val, exp_ser_val); end
      n_vec++; if (req_rdy !== exp_req_rdy) begin n_bad++; $display("FAIL rand req_rdy c%0d: got %b want %b", c, req_rdy, exp_req_rdy); end
      n_vec++; if (send_last !== exp_send_last) begin n_bad++; $display("FAIL rand send_last c%0d: got %b want %b", c, send_last, exp_send_last); end
      n_vec++; if (send_id !== exp_send_id) begin n_bad++; $display("FAIL rand send_id c%0d: got %0d want %0d", c, send_id, exp_send_id); end
      if (exp_ser_val) begin
        n_vec++; if (frame_bad(exp_winner)) begin n_bad++; $display("FAIL rand ser_msg c%0d: got %h want %h", c, ser_msg[0], req_msg[exp_winner*NS]); end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_mon_backpressure();
    test_drop_val();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
